// File: rtl/video_palette_out.sv
// rtl/video_palette_out.sv - palette lookup, blanking and sync alignment for the 8-bit video plex
module video_palette_out #(
    parameter int PAL_AW = 8,
    parameter int COL_W  = 5,
    parameter int SYNC_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                c1,
    input  logic                c3,
    input  logic                hires,
    input  logic [3:0]          hpal,
    input  logic [7:0]          vplex_in,
    input  logic [SYNC_W-1:0]   sync_in,
    input  logic                cram_we,
    input  logic [PAL_AW-1:0]   cram_addr,
    input  logic [3*COL_W-1:0]  cram_wdata,
    output logic [3*COL_W-1:0]  cram_rdata,
    output logic [3*COL_W-1:0]  rgb_out,
    output logic [SYNC_W-1:0]   sync_out
);

    localparam int CW    = 3 * COL_W;
    localparam int DEPTH = 1 << PAL_AW;

    // S0: index select
    logic [PAL_AW-1:0] idx_q, idx_d;
    logic [3:0]        lo_nib_q, lo_nib_d;
    logic              hires_q, hires_d;
    logic [SYNC_W-1:0] s0_sync_q, s0_sync_d;
    logic              s0_v_q, s0_v_d;
    logic [7:0]        idx8;

    // S1: palette read
    logic [CW-1:0]     cram [DEPTH];
    logic [CW-1:0]     cram_q;
    logic [SYNC_W-1:0] s1_sync_q;
    logic              s1_v_q;

    // Pick the palette index for this strobe; c3 uses the hi-res mode latched at c1
    always_comb begin
        idx8      = 8'h00;
        idx_d     = idx_q;
        lo_nib_d  = lo_nib_q;
        hires_d   = hires_q;
        s0_sync_d = s0_sync_q;
        s0_v_d    = 1'b0;
        if (c1) begin
            idx8      = hires ? {hpal, vplex_in[7:4]} : vplex_in;
            idx_d     = idx8[PAL_AW-1:0];
            lo_nib_d  = vplex_in[3:0];
            hires_d   = hires;
            s0_sync_d = sync_in;
            s0_v_d    = 1'b1;
        end else if (c3 && hires_q) begin
            idx8   = {hpal, lo_nib_q};
            idx_d  = idx8[PAL_AW-1:0];
            s0_v_d = 1'b1;
        end
    end

    // Palette storage and pixel read; a same-cycle write to the read address passes straight through
    always_ff @(posedge clk) begin
        if (cram_we) begin
            cram[cram_addr] <= cram_wdata;
        end
        cram_q <= (cram_we && (cram_addr == idx_q)) ? cram_wdata : cram[idx_q];
    end

    // Pipeline control, output stage and CPU read-back port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            lo_nib_q   <= 4'h0;
            hires_q    <= 1'b0;
            s0_sync_q  <= '0;
            s0_v_q     <= 1'b0;
            s1_sync_q  <= '0;
            s1_v_q     <= 1'b0;
            rgb_out    <= '0;
            sync_out   <= {1'b1, {(SYNC_W-1){1'b0}}};
            cram_rdata <= '0;
        end else begin
            idx_q      <= idx_d;
            lo_nib_q   <= lo_nib_d;
            hires_q    <= hires_d;
            s0_sync_q  <= s0_sync_d;
            s0_v_q     <= s0_v_d;
            s1_sync_q  <= s0_sync_q;
            s1_v_q     <= s0_v_q;
            if (s1_v_q) begin
                rgb_out  <= s1_sync_q[SYNC_W-1] ? '0 : cram_q;
                sync_out <= s1_sync_q;
            end
            cram_rdata <= cram_we ? cram_wdata : cram[cram_addr];
        end
    end

endmodule
